branch_target_buffer: RTL
=========================

# branch_target_buffer

Four-entry direct-mapped branch target buffer with 2-bit saturating direction predictors. The fetch stage reads it combinationally to produce the `take`/`addr` pair it loads into `ifid_t`. The execute stage writes it when a branch resolves, using the `bran`, `take` and `addr` fields carried in `idex_t`. It is the update/lookup store behind the `bran_t` entry format.

## Interface
Parameters:
- RESET_STATE, NW, `stateType` value loaded into every entry's counter at reset and flush.

Ports:
- CLK  in  1  system clock, all state on rising edge
- nRST  in  1  asynchronous active-low reset
- fetch_pc  in  32  current fetch PC
- predict_take  out  1  predict taken: hit and counter in TW/TS
- predict_addr  out  30  predicted target word address; 0 on miss
- upd_en  in  1  resolved branch in EX this cycle (idex `bran`)
- upd_pc  in  32  PC of the resolved branch (idex `pc_p4` − 4)
- upd_taken  in  1  actual outcome
- upd_target  in  30  actual target word address
- upd_predicted  in  1  prediction made at fetch (idex `take`)
- btb_flush  in  1  synchronous invalidate of all entries
- stat_updates  out  32  resolved-branch count (BTB_STATS_EN only)
- stat_mispredicts  out  32  mispredict count (BTB_STATS_EN only)

## Operation
- Entry: valid, tag[27:0], addr[29:0], predict_state (NS, NW, TW, TS).
- Index is pc[3:2]. Tag is pc[31:4]. pc[1:0] is ignored.
- Lookup hit: entry valid and tag equals fetch_pc[31:4].
- On lookup hit, predict_take is 1 only when the state is TW or TS. predict_addr = entry addr.
- On lookup miss, both outputs are 0.
- Update when upd_en=1 and btb_flush=0:
  - Tag hit, taken: state steps toward TS (NS→NW→TW→TS, saturates at TS). addr ← upd_target.
  - Tag hit, not taken: state steps toward NS, saturates at NS. addr is unchanged.
  - Tag miss, taken: allocate, replacing any prior occupant. valid=1, tag ← upd_pc[31:4], addr ← upd_target, state=TW.
  - Tag miss, not taken: no change.
- btb_flush=1: every valid cleared and every state set to RESET_STATE. Flush takes priority over a same-cycle update.
- Tag and addr fields are unchanged by flush.
- Reset: all fields 0, state = RESET_STATE, stats 0.
- Combinational outputs are therefore 0 out of reset.

## Timing
- Lookup has zero latency, combinational from fetch_pc and the stored entries.
- An update or flush is visible to lookups from the cycle after its clock edge.
- Same-cycle lookup and update at the same index: the lookup returns the pre-update contents (no bypass).
- Reset asserted mid-update: the update is lost and all state returns to reset values asynchronously.
- Only one update per cycle. No handshake; upd_en is a single-cycle qualifier.

## Configuration
- BTB_STATS_EN defined:
  - Two 32-bit counters and their ports exist.
  - stat_updates increments on every upd_en=1 cycle.
  - stat_mispredicts increments when upd_en=1 and either:
    - upd_predicted ≠ upd_taken, or
    - upd_predicted=upd_taken=1 and the pre-update entry addr ≠ upd_target, or the entry missed.
  - Both counters saturate at 0xFFFFFFFF. btb_flush does not clear them; only nRST does.
- BTB_STATS_EN undefined: counters and stat ports are absent. Prediction behaviour is identical.

## Structure
- `bran_t` and `stateType` live in `pipeline_reg_pkg`. The block imports them and stores `bran_t` [3:0].
- BTB index width and tag offset constants also go in `pipeline_reg_pkg`.
- One sub-module: `sat_counter2`, the 2-bit state next-state function (inputs: state, taken).
- `sat_counter2` is instantiated per update path, not per entry.

## Test plan
- Reset then lookup 0x00000040 → predict_take=0, predict_addr=0. With BTB_STATS_EN, both stats read 0.
- Update pc 0x00000040 taken, target 0x00000100 (word address), then lookup 0x00000040 next cycle → take=1, addr=0x00000100, state TW. Same-cycle lookup returns 0.
- Two not-taken updates on pc 0x40 from TW → TW→NW→NS. Lookup take=0 with addr still 0x00000100. Three taken updates → NS→NW→TW→TS, then stays TS on a fourth.
- Aliasing:
  - Taken update pc 0x00000040, then taken update pc 0x00001040 target 0x200.
  - Lookup 0x40 → miss. Lookup 0x1040 → take=1, addr=0x200.
  - A not-taken update at an untracked pc 0x00000050 → no change.
- btb_flush with a simultaneous upd_en at pc 0x40 → all entries invalid next cycle. The update is dropped. Stats (if enabled) still count the update.
- Stats: upd_predicted=1, upd_taken=0 → stat_mispredicts +1. Then predicted=1, taken=1, target mismatch → +1. Then a correct prediction → stat_updates +1 only.

Source files
------------

// File: rtl/pipeline_reg_pkg.sv
// Shared pipeline-register types: branch entry format, predictor state, BTB geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_reg_pkg;

    localparam int BTB_IDX_W   = 2;
    localparam int BTB_ENTRIES = 1 << BTB_IDX_W;
    localparam int BTB_IDX_LSB = 2;
    localparam int BTB_TAG_LSB = BTB_IDX_LSB + BTB_IDX_W;
    localparam int BTB_TAG_W   = 32 - BTB_TAG_LSB;
    localparam int WORD_ADDR_W = 30;

    // 2-bit direction predictor: strongly/weakly not-taken, weakly/strongly taken
    typedef enum logic [1:0] {
        NS = 2'b00,
        NW = 2'b01,
        TW = 2'b10,
        TS = 2'b11
    } stateType;

    typedef struct packed {
        logic                   valid;
        logic [BTB_TAG_W-1:0]   tag;
        logic [WORD_ADDR_W-1:0] addr;
        stateType               predict_state;
    } bran_t;

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// 2-bit saturating direction counter next-state function.
// Latency: combinational.
// Backpressure: none.
module sat_counter2
    import pipeline_reg_pkg::*;
(
    input  stateType state,
    input  logic     taken,
    output stateType next_state
);

    // step one state toward TS on taken, toward NS otherwise, saturating at both ends
    always_comb begin
        next_state = state;
        unique case (state)
            NS: next_state = taken ? NW : NS;
            NW: next_state = taken ? TW : NS;
            TW: next_state = taken ? TS : NW;
            TS: next_state = taken ? TS : TW;
            default: next_state = state;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Four-entry direct-mapped BTB with 2-bit predictors; optional stats under BTB_STATS_EN.
// Latency: lookup combinational; update/flush visible the cycle after the clock edge.
// Backpressure: none; upd_en is a single-cycle qualifier, one update per cycle.
module branch_target_buffer
    import pipeline_reg_pkg::*;
#(
    parameter stateType RESET_STATE = NW
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [31:0]            fetch_pc,
    output logic                   predict_take,
    output logic [WORD_ADDR_W-1:0] predict_addr,
    input  logic                   upd_en,
    input  logic [31:0]            upd_pc,
    input  logic                   upd_taken,
    input  logic [WORD_ADDR_W-1:0] upd_target,
    input  logic                   upd_predicted,
    input  logic                   btb_flush
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]            stat_updates,
    output logic [31:0]            stat_mispredicts
`endif
);

    bran_t btb [BTB_ENTRIES];

    logic [BTB_IDX_W-1:0] fetch_idx;
    logic [BTB_IDX_W-1:0] upd_idx;
    bran_t                fetch_ent;
    logic                 fetch_hit;
    logic                 upd_hit;
    stateType             upd_cur_state;
    stateType             upd_next_state;

    // word-offset bits of the PCs play no part in indexing or tagging
    logic [3:0] unused_pc_bits;
    assign unused_pc_bits = {fetch_pc[1:0], upd_pc[1:0]};

    assign fetch_idx = fetch_pc[BTB_TAG_LSB-1:BTB_IDX_LSB];
    assign upd_idx   = upd_pc[BTB_TAG_LSB-1:BTB_IDX_LSB];

    // fetch lookup: a hit requires a valid entry with a matching tag; miss drives zeros
    always_comb begin
        fetch_ent    = btb[fetch_idx];
        fetch_hit    = fetch_ent.valid && (fetch_ent.tag == fetch_pc[31:BTB_TAG_LSB]);
        predict_take = 1'b0;
        predict_addr = '0;
        if (fetch_hit) begin
            predict_take = fetch_ent.predict_state inside {TW, TS};
            predict_addr = fetch_ent.addr;
        end
    end

    // pre-update view of the entry the resolving branch maps to
    always_comb begin
        upd_cur_state = btb[upd_idx].predict_state;
        upd_hit       = btb[upd_idx].valid && (btb[upd_idx].tag == upd_pc[31:BTB_TAG_LSB]);
    end

    // single counter on the update path; entries share it since only one updates per cycle
    sat_counter2 u_upd_counter (
        .state      (upd_cur_state),
        .taken      (upd_taken),
        .next_state (upd_next_state)
    );

    // entry store: flush wins over update; a taken miss replaces the slot's occupant
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i].valid         <= 1'b0;
                btb[i].tag           <= '0;
                btb[i].addr          <= '0;
                btb[i].predict_state <= RESET_STATE;
            end
        end else if (btb_flush) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i].valid         <= 1'b0;
                btb[i].predict_state <= RESET_STATE;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                btb[upd_idx].predict_state <= upd_next_state;
                if (upd_taken) begin
                    btb[upd_idx].addr <= upd_target;
                end
            end else if (upd_taken) begin
                btb[upd_idx].valid         <= 1'b1;
                btb[upd_idx].tag           <= upd_pc[31:BTB_TAG_LSB];
                btb[upd_idx].addr          <= upd_target;
                btb[upd_idx].predict_state <= TW;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic upd_mispredict;

    // wrong direction, or taken-as-predicted but to the wrong (or an untracked) target
    assign upd_mispredict = (upd_predicted != upd_taken) ||
                            (upd_predicted && upd_taken &&
                             (!upd_hit || (btb[upd_idx].addr != upd_target)));

    // saturating counters; flush leaves them alone since they describe the program, not the BTB
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else if (upd_en) begin
            if (stat_updates != '1) begin
                stat_updates <= stat_updates + 32'd1;
            end
            if (upd_mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`else
    logic unused_upd_predicted;
    assign unused_upd_predicted = upd_predicted;
`endif

endmodule
